// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide issue controller: opcodes, flag bit positions, FSM states.
package muldiv_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_SMUL = 8'h22;
  localparam logic [7:0] OP_DIV  = 8'h0F;

  localparam int FLAG_Z   = 3;
  localparam int FLAG_S   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_OVR = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_sat_cnt.sv
// 8-bit saturating counter with synchronous clear (priority) and count enable.
module muldiv_sat_cnt (
  input  logic       clk,
  input  logic       a_reset_l,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [7:0] o_cnt
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue-side controller for the multi-cycle multiply/divide unit.
// Optional BUSY watchdog is compiled in with MULDIV_TIMEOUT_EN.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int data_wl        = 16,
  parameter int op_wl          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               a_reset_l,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [data_wl-1:0] req_a,
  input  logic [data_wl-1:0] req_b,
  input  logic [op_wl-1:0]   req_op,
  input  logic [3:0]         req_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [data_wl-1:0] rsp_c,
  output logic [3:0]         rsp_flags,
  output logic               rsp_err,
  output logic [7:0]         rsp_cycles,
  output logic [data_wl-1:0] md_a,
  output logic [data_wl-1:0] md_b,
  output logic [op_wl-1:0]   md_op,
  output logic [3:0]         md_flags,
  input  logic [data_wl-1:0] md_c,
  input  logic [3:0]         md_flags_in,
  input  logic               md_valid,
  input  logic               md_active
);

  state_t             r_state;
  state_t             w_next;
  logic [data_wl-1:0] r_a;
  logic [data_wl-1:0] r_b;
  logic [op_wl-1:0]   r_op;
  logic [3:0]         r_flags;
  logic [data_wl-1:0] r_rsp_c;
  logic [3:0]         r_rsp_flags;
  logic               r_rsp_err;
  logic [7:0]         w_cnt;
  logic               w_accept;
  logic               w_req_supported;
  logic               w_busy;
  logic               w_timeout;
  logic               w_abort;

  assign w_req_supported = (req_op == op_wl'(OP_MUL))  ||
                           (req_op == op_wl'(OP_SMUL)) ||
                           (req_op == op_wl'(OP_DIV));
  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_busy   = (r_state == ST_BUSY);

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  // Counter still holds the pre-increment value, so the last allowed BUSY cycle is TIMEOUT_CYCLES-1.
  assign w_timeout = w_busy && (w_cnt >= TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_abort = !md_active || w_timeout;

  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (req_valid) w_next = w_req_supported ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_valid || w_abort) w_next = ST_DONE;
      ST_DONE: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    md_op     = op_wl'(OP_NOP);
    unique case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_BUSY: md_op     = r_op;
      ST_DONE: rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_flags <= 4'd0;
    end else if (w_accept) begin
      r_a     <= req_a;
      r_b     <= req_b;
      r_op    <= req_op;
      r_flags <= req_flags;
    end
  end

  // Response payload is only written on entry to DONE, so it stays put while the consumer stalls.
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      r_rsp_c     <= '0;
      r_rsp_flags <= 4'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept && !w_req_supported) begin
      r_rsp_c     <= '0;
      r_rsp_flags <= req_flags;
      r_rsp_err   <= 1'b1;
    end else if (w_busy && md_valid) begin
      r_rsp_c     <= md_c;
      r_rsp_flags <= md_flags_in;
      r_rsp_err   <= 1'b0;
    end else if (w_busy && w_abort) begin
      r_rsp_c     <= '0;
      r_rsp_flags <= r_flags;
      r_rsp_err   <= 1'b1;
    end
  end

  muldiv_sat_cnt u_cnt (
    .clk       (clk),
    .a_reset_l (a_reset_l),
    .i_clr     (w_accept),
    .i_en      (w_busy),
    .o_cnt     (w_cnt)
  );

  assign md_a       = r_a;
  assign md_b       = r_b;
  assign md_flags   = r_flags;
  assign rsp_c      = r_rsp_c;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;
  assign rsp_cycles = w_cnt;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed scoreboard bench for muldiv_issue_ctrl with a behavioural multiply/divide unit model.
module tb_muldiv_issue_ctrl;

  logic        clk = 1'b0;
  logic        a_reset_l = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [7:0]  req_op = '0;
  logic [3:0]  req_flags = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [7:0]  rsp_cycles;
  logic [15:0] md_a;
  logic [15:0] md_b;
  logic [7:0]  md_op;
  logic [3:0]  md_flags;
  logic [15:0] md_c = '0;
  logic [3:0]  md_flags_in = '0;
  logic        md_valid = 1'b0;
  logic        md_active = 1'b0;

  muldiv_issue_ctrl dut (
    .clk         (clk),
    .a_reset_l   (a_reset_l),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_flags   (req_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_c       (rsp_c),
    .rsp_flags   (rsp_flags),
    .rsp_err     (rsp_err),
    .rsp_cycles  (rsp_cycles),
    .md_a        (md_a),
    .md_b        (md_b),
    .md_op       (md_op),
    .md_flags    (md_flags),
    .md_c        (md_c),
    .md_flags_in (md_flags_in),
    .md_valid    (md_valid),
    .md_active   (md_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c;
    logic [3:0]  flags;
    logic        err;
    logic [7:0]  cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   acceptCycle = 0;
  int   handoffCycle = 0;

  int   unitLatency = 16;
  int   unitRejectAt = 0;
  bit   unitNeverValid = 1'b0;
  int   busyCnt = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Unit model: result appears during the unitLatency-th cycle that md_op is non-idle.
  always @(negedge clk) begin
    logic [31:0]        up;
    logic signed [31:0] sp;
    logic [15:0]        res;
    logic               ovr;
    if (md_op != 8'h00) begin
      busyCnt = busyCnt + 1;
      up  = {16'd0, md_a} * {16'd0, md_b};
      sp  = $signed({{16{md_a[15]}}, md_a}) * $signed({{16{md_b[15]}}, md_b});
      ovr = 1'b0;
      res = 16'd0;
      case (md_op)
        8'h02: res = up[15:0];
        8'h22: res = sp[15:0];
        8'h0F: begin
          if (md_b == 16'd0) begin
            res = 16'hFFFF;
            ovr = 1'b1;
          end else begin
            res = md_a / md_b;
          end
        end
        default: res = 16'd0;
      endcase
      md_c        = res;
      md_flags_in = {res == 16'd0, res[15], md_flags[1], ovr};
      md_valid    = !unitNeverValid && (busyCnt == unitLatency);
      md_active   = !((unitRejectAt != 0) && (busyCnt == unitRejectAt));
    end else begin
      busyCnt   = 0;
      md_valid  = 1'b0;
      md_active = 1'b0;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                               input logic [3:0] flags, input int lat, input int rej, input bit never,
                               input logic [15:0] ec, input logic [3:0] ef, input logic ee,
                               input logic [7:0] ecyc, input int elat, input bit push);
    exp_t e;
    int   n;
    bit   supported;
    supported      = (op == 8'h02) || (op == 8'h22) || (op == 8'h0F);
    unitLatency    = lat;
    unitRejectAt   = rej;
    unitNeverValid = never;
    if (push) begin
      e.c = ec; e.flags = ef; e.err = ee; e.cyc = ecyc; e.lat = elat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_flags = flags; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkVal("reqReadyForAccept", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    acceptCycle = cycle;
    @(negedge clk);
    checkVal("mdOpAfterAccept", md_op, supported ? op : 8'h00);
    if (supported) begin
      checkVal("mdA", md_a, a);
      checkVal("mdB", md_b, b);
    end
  endtask

  task automatic checkOutput(input int hold);
    exp_t        e;
    int          n;
    logic [15:0] c0;
    logic [3:0]  f0;
    n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkVal("rspValidSeen", rsp_valid, 1);
    checkVal("sbDepth", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkVal("rspC", rsp_c, e.c);
    checkVal("rspFlags", rsp_flags, e.flags);
    checkVal("rspErr", rsp_err, e.err);
    checkVal("rspCycles", rsp_cycles, e.cyc);
    checkVal("rspLatency", cycle - acceptCycle, e.lat);
    checkVal("mdOpInDone", md_op, 8'h00);
    checkVal("reqReadyInDone", req_ready, 0);
    c0 = rsp_c;
    f0 = rsp_flags;
    if (hold > 0) begin
      req_a = 16'hFFFF; req_b = 16'h1234; req_op = 8'h05; req_flags = 4'hF; req_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkVal("holdValid", rsp_valid, 1);
      checkVal("holdC", rsp_c, c0);
      checkVal("holdFlags", rsp_flags, f0);
      checkVal("holdReqReady", req_ready, 0);
      checkVal("holdMdOp", md_op, 8'h00);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready    = 1'b0;
    handoffCycle = cycle;
    checkVal("rspValidAfterHandoff", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    bit sawValid;
    #2;
    checkVal("resetReqReady", req_ready, 1);
    checkVal("resetRspValid", rsp_valid, 0);
    checkVal("resetRspC", rsp_c, 0);
    checkVal("resetRspFlags", rsp_flags, 0);
    checkVal("resetRspErr", rsp_err, 0);
    checkVal("resetRspCycles", rsp_cycles, 0);
    checkVal("resetMdOp", md_op, 0);
    checkVal("resetMdA", {md_a, md_b}, 0);
    checkVal("resetMdFlags", md_flags, 0);
    repeat (2) @(negedge clk);
    a_reset_l = 1'b1;

    $display("[TB] MUL 3*5");
    applyStimulus(16'd3, 16'd5, 8'h02, 4'b0000, 16, 0, 0, 16'h000F, 4'b0000, 0, 8'd16, 16, 1);
    checkOutput(0);

    $display("[TB] SMUL -2*3 with carry passthrough");
    applyStimulus(16'hFFFE, 16'd3, 8'h22, 4'b0010, 5, 0, 0, 16'hFFFA, 4'b0110, 0, 8'd5, 5, 1);
    checkOutput(0);

    $display("[TB] DIV 100/7");
    applyStimulus(16'd100, 16'd7, 8'h0F, 4'b0000, 20, 0, 0, 16'h000E, 4'b0000, 0, 8'd20, 20, 1);
    checkOutput(0);

    $display("[TB] DIV 5/0 with stalled consumer");
    applyStimulus(16'd5, 16'd0, 8'h0F, 4'b0000, 3, 0, 0, 16'hFFFF, 4'b0101, 0, 8'd3, 3, 1);
    checkOutput(5);

    $display("[TB] unsupported opcode right after handoff");
    applyStimulus(16'h1111, 16'h2222, 8'h05, 4'b1010, 16, 0, 0, 16'h0000, 4'b1010, 1, 8'd0, 0, 1);
    checkVal("acceptAfterHandoff", acceptCycle - handoffCycle, 1);
    checkOutput(0);

    $display("[TB] unit rejection");
    applyStimulus(16'd2, 16'd2, 8'h02, 4'b0001, 16, 4, 0, 16'h0000, 4'b0001, 1, 8'd4, 4, 1);
    checkOutput(0);

    $display("[TB] valid and inactive together");
    applyStimulus(16'd7, 16'd6, 8'h02, 4'b0000, 6, 6, 0, 16'h002A, 4'b0000, 0, 8'd6, 6, 1);
    checkOutput(0);

`ifdef MULDIV_TIMEOUT_EN
    $display("[TB] watchdog expiry");
    applyStimulus(16'd9, 16'd9, 8'h02, 4'b1100, 16, 0, 1, 16'h0000, 4'b1100, 1, 8'd64, 64, 1);
    checkOutput(0);
`else
    $display("[TB] long operation saturates cycle count");
    applyStimulus(16'd1, 16'd1, 8'h02, 4'b0000, 300, 0, 0, 16'h0001, 4'b0000, 0, 8'd255, 300, 1);
    checkOutput(0);
`endif

    $display("[TB] reset during BUSY");
    applyStimulus(16'd3, 16'd3, 8'h02, 4'b0000, 16, 0, 0, 16'h0000, 4'b0000, 0, 8'd0, 0, 0);
    repeat (4) @(negedge clk);
    #1;
    a_reset_l = 1'b0;
    #1;
    checkVal("resetMidBusyMdOp", md_op, 8'h00);
    checkVal("resetMidBusyReqReady", req_ready, 1);
    checkVal("resetMidBusyRspValid", rsp_valid, 0);
    @(negedge clk);
    a_reset_l = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) sawValid = 1'b1;
    end
    checkVal("noRspAfterReset", sawValid, 0);

    $display("[TB] recovery after reset");
    applyStimulus(16'd4, 16'd4, 8'h02, 4'b0000, 2, 0, 0, 16'h0010, 4'b0000, 0, 8'd2, 2, 1);
    checkOutput(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Issue-side controller for the multi-cycle multiply/divide unit. Accepts one operation at a time from the decode/execute stage over a valid/ready request channel and drives the unit's operand, opcode and flag inputs. It holds those inputs stable until the unit signals completion, then captures the result and flags and returns them over a valid/ready response channel. It also guarantees the idle-opcode recovery cycle the unit needs between operations.

## Interface
- data_wl, 16, operand/result width
- op_wl, 8, opcode width
- TIMEOUT_CYCLES, 64, watchdog limit in BUSY cycles (used only with the watchdog compiled in)

- clk  input  1  clock; all state updates on rising edge
- a_reset_l  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_a, req_b  input  data_wl  operands
- req_op  input  op_wl  opcode
- req_flags  input  4  incoming flags {z,s,c,ovr}
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_c  output  data_wl  result
- rsp_flags  output  4  resulting flags {z,s,c,ovr}
- rsp_err  output  1  unsupported opcode, unit rejection, or timeout
- rsp_cycles  output  8  BUSY cycles spent on the operation, saturating at 255
- md_a, md_b  output  data_wl  operands to the unit
- md_op  output  op_wl  opcode to the unit; 8'h00 = idle
- md_flags  output  4  flags to the unit {z,s,c,ovr}
- md_c  input  data_wl  unit result
- md_flags_in  input  4  unit flags {z,s,c,ovr}
- md_valid  input  1  unit result valid
- md_active  input  1  unit recognises md_op

## Operation
- Supported opcodes: MUL 8'h02, SMUL 8'h22, DIV 8'h0F. All others are unsupported.
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - req_ready=1, md_op=8'h00.
  - On req_valid, latch a, b, op and flags.
  - Supported opcode: go to BUSY.
  - Unsupported opcode: go to DONE with rsp_err=1, rsp_c=0, rsp_flags=req_flags, rsp_cycles=0.
- BUSY:
  - req_ready=0. md_a/md_b/md_op/md_flags are driven from the latch and are held constant.
  - On md_valid=1: capture md_c and md_flags_in, rsp_err=0, go to DONE.
  - On md_active=0 (and md_valid=0): go to DONE with rsp_err=1, rsp_c=0, rsp_flags=latched flags.
  - The cycle counter increments each BUSY cycle and saturates at 255.
- DONE:
  - rsp_valid=1, md_op=8'h00, req_ready=0.
  - On rsp_ready, go to IDLE.
  - DONE lasts at least one cycle, which provides the idle-opcode recovery cycle that re-arms the unit's load.
- Response registers hold their values while rsp_valid=1 and rsp_ready=0.
- The c flag is passed straight through by the unit; the controller does not alter it.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_c=0, rsp_flags=0, rsp_err=0, rsp_cycles=0, md_a=0, md_b=0, md_op=0, md_flags=0.
- Asserting reset in any state forces IDLE immediately. md_op becomes 0 asynchronously and any in-flight result is discarded.
- Request accepted at edge N → md_op valid from cycle N+1.
- md_valid sampled high at edge M → rsp_valid from cycle M+1.
- Unsupported opcode → rsp_valid one cycle after acceptance.
- Minimum spacing between accepts is 3 cycles (IDLE, BUSY or DONE, DONE→IDLE). No request is accepted in the same cycle as a response handoff.
- md_valid and md_active=0 in the same cycle: md_valid wins.

## Configuration
- MULDIV_TIMEOUT_EN defined:
  - Watchdog active in BUSY.
  - When the cycle counter reaches TIMEOUT_CYCLES with md_valid=0, go to DONE with rsp_err=1, rsp_c=0, rsp_flags=latched flags.
  - md_valid in the expiry cycle wins.
- MULDIV_TIMEOUT_EN undefined: no watchdog. BUSY waits indefinitely, and TIMEOUT_CYCLES is ignored.

## Structure
- Shared package muldiv_pkg:
  - opcode constants (MUL, SMUL, DIV, NOP=8'h00)
  - flag bit indices (Z=3, S=2, C=1, OVR=0)
  - state encoding.
- One sub-module, muldiv_sat_cnt: an 8-bit saturating counter with clear and enable. It serves both rsp_cycles and the watchdog compare.

## Test plan
- MUL a=3, b=5 with a unit model that asserts valid after 16 cycles → rsp_c=0x000F, z=0, s=0, rsp_err=0, rsp_cycles=16; md_op=0 during DONE.
- SMUL a=0xFFFE, b=3 → rsp_c=0xFFFA, s=1, z=0.
- DIV a=100, b=7 → rsp_c=0x000E. DIV a=5, b=0 → ovr=1 propagated from the unit.
- Unsupported opcode 8'h05 → rsp_valid at cycle 1 after accept, rsp_err=1, rsp_c=0, rsp_flags=req_flags, and md_op never leaves 0.
- rsp_ready held low for 5 cycles after completion → response stable, req_ready=0, md_op=0. The next request is accepted only after the handoff.
- Timeout build, unit model never asserts valid → rsp_err=1 after exactly 64 BUSY cycles.
- Reset pulsed mid-BUSY → md_op=0 immediately, req_ready=1, and no rsp_valid is produced.
